// File: rtl/top_cpu_core.sv
// Tiny accumulator CPU with a fixed ROM program and an 8N1 UART.
// The ROM echoes every received byte plus one.
module top_cpu_core #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic tx
);
  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  localparam logic [3:0] OP_IN   = 4'd1;
  localparam logic [3:0] OP_OUT  = 4'd2;
  localparam logic [3:0] OP_ADDI = 4'd3;
  localparam logic [3:0] OP_JMP  = 4'd4;
  localparam logic [3:0] OP_JZ   = 4'd5;
  localparam logic [3:0] OP_LDI  = 4'd6;
  localparam logic [3:0] OP_XORI = 4'd7;

  logic          rx_s1, rx_s2, rx_prev;
  logic [1:0]    rx_state;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_sh, rx_buf;
  logic          rx_valid, rx_done;

  logic [3:0]    pc;
  logic [7:0]    acc, instr;
  logic [3:0]    op, imm;
  logic          in_take, out_go;

  logic          tx_busy;
  logic [CW-1:0] tx_cnt;
  logic [3:0]    tx_bit;
  logic [8:0]    tx_sh;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_sh    <= '0;
    end else begin
      case (rx_state)
        RX_IDLE: if (rx_prev && !rx_s2) begin
          rx_state <= RX_START;
          rx_cnt   <= '0;
        end
        RX_START: if (rx_cnt == HALF_M1) begin
          rx_cnt   <= '0;
          rx_bit   <= '0;
          rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
        end else rx_cnt <= rx_cnt + 1'b1;
        RX_DATA: if (rx_cnt == FULL_M1) begin
          rx_cnt <= '0;
          rx_sh  <= {rx_s2, rx_sh[7:1]};
          rx_bit <= rx_bit + 1'b1;
          if (rx_bit == 3'd7) rx_state <= RX_STOP;
        end else rx_cnt <= rx_cnt + 1'b1;
        default: if (rx_cnt == FULL_M1) begin
          rx_cnt   <= '0;
          rx_state <= RX_IDLE;
        end else rx_cnt <= rx_cnt + 1'b1;
      endcase
    end
  end

  assign rx_done = (rx_state == RX_STOP) && (rx_cnt == FULL_M1) && rx_s2;

  // A completing byte outranks the IN clear, so the flag survives a same-cycle take.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_buf   <= '0;
      rx_valid <= 1'b0;
    end else if (rx_done) begin
      rx_buf   <= rx_sh;
      rx_valid <= 1'b1;
    end else if (in_take) begin
      rx_valid <= 1'b0;
    end
  end

  always_comb begin
    instr = 8'h00;
    case (pc)
      4'd0:    instr = 8'h10;
      4'd1:    instr = 8'h31;
      4'd2:    instr = 8'h20;
      4'd3:    instr = 8'h40;
      default: instr = 8'h00;
    endcase
  end

  assign op      = instr[7:4];
  assign imm     = instr[3:0];
  assign in_take = (op == OP_IN) && rx_valid;
  assign out_go  = (op == OP_OUT) && !tx_busy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc  <= '0;
      acc <= '0;
    end else begin
      case (op)
        OP_IN: if (rx_valid) begin
          acc <= rx_buf;
          pc  <= pc + 1'b1;
        end
        OP_OUT:  if (!tx_busy) pc <= pc + 1'b1;
        OP_ADDI: begin acc <= acc + {4'h0, imm}; pc <= pc + 1'b1; end
        OP_JMP:  pc <= imm;
        OP_JZ:   pc <= (acc == 8'h00) ? imm : pc + 1'b1;
        OP_LDI:  begin acc <= {4'h0, imm}; pc <= pc + 1'b1; end
        OP_XORI: begin acc <= acc ^ {4'h0, imm}; pc <= pc + 1'b1; end
        default: pc <= pc + 1'b1;
      endcase
    end
  end

  // Start bit is driven on the load edge; tx_sh holds data bits then the stop bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx      <= 1'b1;
      tx_busy <= 1'b0;
      tx_cnt  <= '0;
      tx_bit  <= '0;
      tx_sh   <= '0;
    end else if (!tx_busy) begin
      if (out_go) begin
        tx      <= 1'b0;
        tx_busy <= 1'b1;
        tx_cnt  <= '0;
        tx_bit  <= '0;
        tx_sh   <= {1'b1, acc};
      end
    end else if (tx_cnt == FULL_M1) begin
      tx_cnt <= '0;
      if (tx_bit == 4'd9) begin
        tx_busy <= 1'b0;
        tx_bit  <= '0;
      end else begin
        tx_bit <= tx_bit + 1'b1;
        tx     <= tx_sh[0];
        tx_sh  <= {1'b1, tx_sh[8:1]};
      end
    end else begin
      tx_cnt <= tx_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_top_cpu_core.sv
// Bench for top_cpu_core: drives UART frames on rx and decodes tx against
// a queue of expected echo bytes (received byte + 1 for each good frame).
module tb_top_cpu_core;
  localparam int unsigned CPB = 16;

  logic clk = 1'b0;
  logic rst, rx, tx;

  top_cpu_core #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk),
    .rst(rst),
    .rx (rx),
    .tx (tx)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned n_cmp = 0, n_bad = 0;
  int unsigned n_frames = 0, last_start = 0, stop_mid = 0;
  logic [7:0]  expq[$];
  bit          mon_busy = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stopb);
    logic [9:0] f;
    f = {stopb, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = f[i];
      if (i == 9) begin
        idle(CPB / 2);
        stop_mid = cyc;
        idle(CPB - CPB / 2);
      end else begin
        idle(CPB);
      end
    end
    rx = 1'b1;
  endtask

  task automatic glitch(input int unsigned len);
    rx = 1'b0;
    idle(len);
    rx = 1'b1;
  endtask

  task automatic drain(input int unsigned budget, input string name);
    int unsigned t = 0;
    while ((expq.size() != 0 || mon_busy) && t < budget) begin
      idle(1);
      t++;
    end
    check(name, expq.size(), 0);
    expq.delete();
  endtask

  // Decodes every tx frame, checks per-bit duration and data against the queue.
  initial begin : monitor
    logic       s [0:10*CPB-1];
    logic [9:0] bits;
    logic [7:0] exp_b;
    bit         aborted, tim_ok;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && tx === 1'b0) begin
        mon_busy   = 1'b1;
        last_start = cyc;
        aborted    = 1'b0;
        for (int i = 0; i < 10 * CPB; i++) begin
          if (i > 0) @(negedge clk);
          if (rst !== 1'b1) begin
            aborted = 1'b1;
            break;
          end
          s[i] = tx;
        end
        if (!aborted) begin
          tim_ok = 1'b1;
          for (int b = 0; b < 10; b++) begin
            bits[b] = s[b*CPB + CPB/2];
            for (int k = 0; k < CPB; k++)
              if (s[b*CPB + k] !== bits[b]) tim_ok = 1'b0;
          end
          n_frames++;
          check("tx_bit_timing", {31'd0, tim_ok}, 1);
          check("tx_start_stop", {30'd0, bits[9], bits[0]}, 2'b10);
          if (expq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL tx_unexpected_frame: got byte 0x%02h, expected no frame (cycle %0d)",
                     bits[8:1], cyc);
          end else begin
            exp_b = expq.pop_front();
            check("tx_byte", bits[8:1], exp_b);
          end
        end
        mon_busy = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int unsigned nf, t, k;
    logic [7:0]  b;
    rst = 1'b0;
    rx  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("reset_tx_high", {31'd0, tx}, 1);
    end
    rst = 1'b1;
    idle(1000);
    check("idle_no_frames", n_frames, 0);

    expq.push_back(8'h42);
    send_frame(8'h41, 1'b1);
    drain(600, "echo_41_drain");
    check("echo_41_latency", {31'd0, (last_start > stop_mid) && (last_start - stop_mid <= 8)}, 1);

    expq.push_back(8'h00);
    send_frame(8'hFF, 1'b1);
    drain(600, "echo_ff_wrap_drain");

    expq.push_back(8'h11);
    expq.push_back(8'h21);
    send_frame(8'h10, 1'b1);
    send_frame(8'h20, 1'b1);
    drain(1200, "back_to_back_drain");

    nf = n_frames;
    glitch(CPB / 2 - 1);
    idle(40);
    send_frame(8'h55, 1'b0);
    idle(400);
    check("no_echo_glitch_or_framing_err", n_frames - nf, 0);

    expq.push_back(8'h78);
    send_frame(8'h77, 1'b1);
    t = 0;
    while (!mon_busy && t < 200) begin
      idle(1);
      t++;
    end
    check("tx_frame_started", {31'd0, mon_busy}, 1);
    idle(40);
    @(posedge clk);
    #2 rst = 1'b0;
    #1 check("tx_async_reset", {31'd0, tx}, 1);
    expq.delete();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("tx_high_in_reset", {31'd0, tx}, 1);
    end
    rst = 1'b1;
    idle(4);
    expq.push_back(8'h5B);
    send_frame(8'h5A, 1'b1);
    drain(600, "echo_after_reset_drain");

    for (int n = 0; n < 24; n++) begin
      k = $urandom_range(0, 9);
      b = 8'($urandom);
      if (k == 0) begin
        glitch($urandom_range(1, CPB / 2 - 2));
      end else if (k == 1) begin
        send_frame(b, 1'b0);
      end else begin
        expq.push_back(b + 8'd1);
        send_frame(b, 1'b1);
      end
      idle($urandom_range(8, 3 * CPB));
    end
    drain(3000, "random_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
